// File: rtl/alu_pkg.sv
// Shared ALU definitions: alu_control op codes, op type and exec-stage FSM states.
// Used by the ALU control decoder and the execute unit.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD   = 4'b0000;
  localparam alu_op_t ALU_SUB   = 4'b0001;
  localparam alu_op_t ALU_SLL   = 4'b0010;
  localparam alu_op_t ALU_SLT   = 4'b0011;
  localparam alu_op_t ALU_SLTU  = 4'b0100;
  localparam alu_op_t ALU_XOR   = 4'b0101;
  localparam alu_op_t ALU_SRL   = 4'b0110;
  localparam alu_op_t ALU_SRA   = 4'b0111;
  localparam alu_op_t ALU_OR    = 4'b1000;
  localparam alu_op_t ALU_AND   = 4'b1001;
  localparam alu_op_t ALU_PASSB = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } exec_state_t;

  function automatic logic is_shift_op(alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational ALU core: single-cycle ops on the request operands, plus one
// bounded shift step applied to the iteration's working value.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STEP_W = 1
) (
  input  alu_op_t           i_op,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [XLEN-1:0]   o_result,
  input  alu_op_t           i_sh_op,
  input  logic [XLEN-1:0]   i_sh_val,
  input  logic [STEP_W-1:0] i_sh_step,
  output logic [XLEN-1:0]   o_sh_val
);

  always_comb begin
    o_result = i_a + i_b;
    case (i_op)
      ALU_SUB:   o_result = i_a - i_b;
      ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, i_a < i_b};
      ALU_XOR:   o_result = i_a ^ i_b;
      ALU_OR:    o_result = i_a | i_b;
      ALU_AND:   o_result = i_a & i_b;
      ALU_PASSB: o_result = i_b;
      // Only zero-amount shifts take this path; others iterate.
      ALU_SLL, ALU_SRL, ALU_SRA: o_result = i_a;
      default:   o_result = i_a + i_b;
    endcase
  end

  always_comb begin
    o_sh_val = i_sh_val;
    case (i_sh_op)
      ALU_SLL: o_sh_val = i_sh_val << i_sh_step;
      ALU_SRL: o_sh_val = i_sh_val >> i_sh_step;
      ALU_SRA: o_sh_val = $unsigned($signed(i_sh_val) >>> i_sh_step);
      default: o_sh_val = i_sh_val;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes; shifts iterate SHIFT_PER_CYCLE
// bit positions per cycle, everything else completes in one cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned SHIFT_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      alu_control_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  localparam int unsigned CntW  = $clog2(XLEN);
  localparam int unsigned StepW = $clog2(SHIFT_PER_CYCLE) + 1;

  exec_state_t r_state, w_state_next;
  alu_op_t     r_op;
  logic [XLEN-1:0] r_val, r_result;
  logic [CntW-1:0] r_count;

  logic            w_accept;
  logic [CntW-1:0] w_in_amt;
  logic            w_in_iter;
  logic            w_last_step;
  logic [StepW-1:0] w_step;
  logic [XLEN-1:0] w_core_result, w_sh_val;

  assign w_in_amt    = b_i[CntW-1:0];
  assign w_in_iter   = is_shift_op(alu_control_i) && (w_in_amt != '0);
  assign w_last_step = (r_count <= CntW'(SHIFT_PER_CYCLE));
  // On the last step the remainder is <= SHIFT_PER_CYCLE, so it fits in StepW.
  assign w_step      = w_last_step ? StepW'(r_count) : StepW'(SHIFT_PER_CYCLE);
  assign w_accept    = in_valid_i && in_ready_o;

  alu_comb_core #(
    .XLEN   (XLEN),
    .STEP_W (StepW)
  ) u_core (
    .i_op      (alu_control_i),
    .i_a       (a_i),
    .i_b       (b_i),
    .o_result  (w_core_result),
    .i_sh_op   (r_op),
    .i_sh_val  (r_val),
    .i_sh_step (w_step),
    .o_sh_val  (w_sh_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush_i) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) w_state_next = w_in_iter ? SHIFT : DONE;
        end
        SHIFT: begin
          if (w_last_step) w_state_next = DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            if (w_accept) w_state_next = w_in_iter ? SHIFT : DONE;
            else          w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = ((r_state == IDLE) || ((r_state == DONE) && out_ready_i)) && !flush_i;
    out_valid_o = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= ALU_ADD;
      r_val    <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= alu_control_i;
      r_val   <= a_i;
      r_count <= w_in_amt;
      if (!w_in_iter) r_result <= w_core_result;
    end else if ((r_state == SHIFT) && !flush_i) begin
      r_val   <= w_sh_val;
      r_count <= r_count - CntW'(w_step);
      if (w_last_step) r_result <= w_sh_val;
    end
  end

  assign result_o = r_result;
  assign zero_o   = (r_result == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised self-checking bench for alu_exec_unit against a behavioural model
// of the op results and handshake latency.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned SPC  = 1;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, zero;
  logic [3:0]  ctl;
  logic [31:0] a_in, b_in, result;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_unit #(
    .XLEN            (XLEN),
    .SHIFT_PER_CYCLE (SPC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .alu_control_i (ctl),
    .a_i           (a_in),
    .b_i           (b_in),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .result_o      (result),
    .zero_o        (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    int unsigned sh = b % 32;
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_SLL:   return a << sh;
      ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:   return a ^ b;
      ALU_SRL:   return a >> sh;
      ALU_SRA:   return $signed(a) >>> sh;
      ALU_OR:    return a | b;
      ALU_AND:   return a & b;
      ALU_PASSB: return b;
      default:   return a + b;
    endcase
  endfunction

  function automatic int ref_latency(logic [3:0] op, logic [31:0] b);
    int unsigned sh = b % 32;
    if ((op == ALU_SLL || op == ALU_SRL || op == ALU_SRA) && sh != 0)
      return (sh + SPC - 1) / SPC + 1;
    return 1;
  endfunction

  // Issue one op from IDLE, hold out_ready low for `stall` cycles once valid,
  // then consume; returns just after the consuming edge.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int stall, input string tag);
    logic [31:0] exp_res;
    int lat, busy;
    exp_res   = ref_result(op, a, b);
    in_valid  = 1'b1;
    ctl       = op;
    a_in      = a;
    b_in      = b;
    out_ready = (stall == 0);
    @(negedge clk);
    chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ctl      = 4'($urandom);
    a_in     = $urandom;
    b_in     = $urandom;
    lat  = 1;
    busy = 0;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      if (in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, ref_latency(op, b));
    chk({tag, " ready while busy"}, busy, 0);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " zero"}, {31'b0, zero}, {31'b0, exp_res == 32'd0});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (i == stall - 1) out_ready = 1'b1;
      @(negedge clk);
      chk({tag, " held valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, " held result"}, result, exp_res);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] xa, xb, prev, ra, rb;
    logic [3:0]  rop;
    int seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ctl = '0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset zero", {31'b0, zero}, 32'd1);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    do_op(ALU_ADD, 32'd7, 32'd5, 0, "add");
    do_op(ALU_SUB, 32'd5, 32'd5, 0, "sub zero");
    do_op(ALU_SRA, 32'h8000_0000, 32'd4, 0, "sra");
    do_op(ALU_SLL, 32'h0000_1235, 32'h23, 0, "sll amt3");
    do_op(4'b1101, 32'd2, 32'd3, 0, "unused code");
    do_op(ALU_PASSB, 32'hDEAD_BEEF, 32'h1234_5000, 0, "passb");
    do_op(ALU_SRL, 32'hCAFE_F00D, 32'd0, 0, "shift zero");
    do_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 0, "slt neg");

    // Backpressure, then back-to-back acceptance on the releasing cycle.
    in_valid = 1'b1; ctl = ALU_SLTU; a_in = 32'd1; b_in = 32'hFFFF_FFFF; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp valid", {31'b0, out_valid}, 32'd1);
      chk("bp result", result, 32'd1);
      chk("bp in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    xa = $urandom; xb = $urandom;
    out_ready = 1'b1; in_valid = 1'b1; ctl = ALU_XOR; a_in = xa; b_in = xb;
    @(negedge clk);
    chk("b2b in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b valid", {31'b0, out_valid}, 32'd1);
    chk("b2b result", result, xa ^ xb);
    @(posedge clk); #1;
    prev = xa ^ xb;

    // Flush mid-shift.
    in_valid = 1'b1; ctl = ALU_SRL; a_in = $urandom; b_in = 32'd20;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("post flush in_ready", {31'b0, in_ready}, 32'd1);
    chk("post flush valid", {31'b0, out_valid}, 32'd0);
    chk("post flush result", result, prev);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flushed op never valid", seen, 0);

    // Flush with a request in IDLE.
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; ctl = ALU_ADD; a_in = 32'd1; b_in = 32'd1;
    @(negedge clk);
    chk("idle flush in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("idle flush no accept", {31'b0, out_valid}, 32'd0);
    chk("idle flush result", result, prev);
    @(posedge clk); #1;

    for (int n = 0; n < 200; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) rb = rb & 32'h0000_0003;
      do_op(rop, ra, rb, $urandom_range(0, 3), "random");
    end

    // Reset while a result is held.
    in_valid = 1'b1; ctl = ALU_ADD; a_in = 32'd9; b_in = 32'd9; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("pre-rst valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst done valid", {31'b0, out_valid}, 32'd0);
    chk("rst done result", result, 32'd0);
    chk("rst done zero", {31'b0, zero}, 32'd1);
    chk("rst done in_ready", {31'b0, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage datapath that consumes the 4-bit alu_control code produced by the ALU control decoder.
- Shifts (SLL/SRL/SRA) are iterative, SHIFT_PER_CYCLE bit positions per cycle; all other ops finish in one cycle.
- Uses valid/ready handshakes on input and output, so it sits between decode and writeback in the multi-cycle core variant.
- Also produces zero_o for the branch compare (SUB).

Parameters:
- XLEN, 32, operand and result width. Must be a power of two, at least 8.
- SHIFT_PER_CYCLE, 1, bit positions shifted per iteration. Must be a power of two, 1..XLEN/2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  abort the in-flight op and drop any held result.
- in_valid_i  in  1  operation request.
- in_ready_o  out  1  unit can accept a request this cycle.
- alu_control_i  in  4  op code, captured on acceptance.
- a_i  in  XLEN  operand A (rs1 / pc).
- b_i  in  XLEN  operand B (rs2 / imm).
- out_valid_o  out  1  result_o / zero_o valid.
- out_ready_i  in  1  consumer takes the result.
- result_o  out  XLEN  registered result.
- zero_o  out  1  result_o == 0.

Behaviour:
- Op codes (shared package): ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASS_B 1010. Codes 1011..1111 execute as ADD.
- Arithmetic:
  - ADD and SUB wrap modulo 2^XLEN.
  - SLT is signed and SLTU is unsigned; both give result {XLEN-1 zeros, flag}.
  - PASS_B gives b_i.
  - Shift amount = b_i[log2(XLEN)-1:0]; upper bits ignored.
  - SRA replicates the operand sign bit.
- FSM states:
  - IDLE: no op held.
  - SHIFT: iterating; holds working value and remaining count.
  - DONE: result held.
- in_ready_o = (IDLE or (DONE and out_ready_i)) and not flush_i. It is combinational.
- Acceptance = in_valid_i and in_ready_o. It captures op, a_i and b_i, then:
  - Non-shift op, or shift with amount 0: result registered, state goes to DONE next cycle (latency 1).
  - Shift with amount > 0: state goes to SHIFT.
- SHIFT, each cycle:
  - Shift by min(SHIFT_PER_CYCLE, remaining); remaining decreases by the same amount.
  - When remaining reaches 0, load result and go to DONE.
  - Latency from acceptance to out_valid_o = ceil(amount/SHIFT_PER_CYCLE) + 1 cycles.
  - in_ready_o = 0 throughout.
- DONE:
  - out_valid_o = 1.
  - result_o and zero_o stay stable until the handshake (out_valid_o and out_ready_i).
  - On handshake without a new acceptance, go to IDLE.
  - On handshake with a same-cycle acceptance, the next op starts back-to-back; no bubble for 1-cycle ops.
- out_valid_o = 1 only in DONE.
- result_o keeps its last value in IDLE and SHIFT; zero_o tracks result_o.
- flush_i (any state): next state is IDLE, out_valid_o drops next cycle, no acceptance that cycle. flush_i takes priority over out_ready_i and in_valid_i. result_o is not cleared.
- Reset values:
  - state IDLE, out_valid_o 0, result_o 0, zero_o 1.
  - in_ready_o is 1 in the first cycle after rst deasserts.
  - rst mid-SHIFT or in DONE discards the op.
- Inputs are not sampled outside acceptance. Changing a_i, b_i or alu_control_i during SHIFT has no effect.

Decomposition:
- Shared package alu_pkg holds:
  - the alu_control localparams (ALU_ADD..ALU_PASSB);
  - the alu_op_t 4-bit typedef;
  - the exec_state_t enum {IDLE, SHIFT, DONE}.
  - The ALU control decoder is updated to use the same package.
- One natural sub-module, alu_comb_core: purely combinational, covers all non-shift ops plus the single-step shift used by the iteration. The FSM, counters and handshake stay in alu_exec_unit.

Test Plan:
- Reset then ADD a=7, b=5 with out_ready=1 → out_valid 1 cycle after acceptance, result 12, zero 0. SUB a=5, b=5 → result 0, zero 1.
- SRA a=0x80000000, b=4, SHIFT_PER_CYCLE=1:
  - in_ready low for 4 cycles;
  - out_valid at cycle 5 with result 0xF8000000.
  - SLL with b=0x23: amount 3, result a<<3 after 4 cycles.
- Backpressure: hold out_ready=0 for 3 cycles with SLTU a=1, b=0xFFFFFFFF → result 1 held stable. Then raise out_ready with a new XOR request the same cycle → back-to-back, second result next cycle.
- flush_i asserted mid-SHIFT (SRL b=20) → out_valid never asserts for that op, in_ready is 1 the cycle after flush. flush_i with in_valid in IDLE → request not accepted.
- Unused code 1101 with a=2, b=3 → result 5. PASS_B b=0x12345000 → result 0x12345000. Shift with b=0 → 1-cycle latency, result = a.
- rst asserted during DONE with out_ready=0 → next cycle out_valid 0, result 0, zero 1, in_ready 1.
